// File: rtl/wm_pkg.sv
// Shared types for the washing-machine panel: program codes, panel states
// and the double-dabble step used by the BCD converter.
package wm_pkg;

  typedef enum logic [2:0] {
    COLD_WASH   = 3'b000,
    HOT_WASH    = 3'b001,
    RINSING_DRY = 3'b010,
    ONLY_DRY    = 3'b011,
    WARM_WASH   = 3'b100
  } prog_t;

  typedef enum logic [1:0] {
    SELECT  = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    DONE    = 2'd3
  } panel_t;

  localparam int NUM_BTN   = 2;
  localparam int BTN_PROG  = 0;
  localparam int BTN_START = 1;

  // One double-dabble iteration on {hundreds, tens, ones, binary}.
  function automatic logic [19:0] dd_step(input logic [19:0] sr);
    logic [19:0] t;
    t = sr;
    for (int d = 0; d < 3; d++)
      if (t[8+4*d +: 4] >= 4'd5) t[8+4*d +: 4] = t[8+4*d +: 4] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/wm_bin2bcd.sv
// 8-bit sequential double-dabble: one load cycle, eight shift cycles, digits
// land together with the done pulse.
module wm_bin2bcd
  import wm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [1:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  logic [19:0] sr, sr_nxt;
  logic [2:0]  cnt;
  logic [1:0]  unused_hi;

  assign sr_nxt    = dd_step(sr);
  assign unused_hi = sr_nxt[19:18];

  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hundreds <= '0;
      tens     <= '0;
      ones     <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        sr   <= {12'd0, din};
        cnt  <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        sr <= sr_nxt;
        if (cnt == 3'd7) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          hundreds <= sr_nxt[17:16];
          tens     <= sr_nxt[15:12];
          ones     <= sr_nxt[11:8];
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/wm_debounce.sv
// Button input path: 2-FF synchronizer, stability counter, rising-edge press pulse.
module wm_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        level <= sync[1];
        press <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wm_control_panel.sv
// Washing-machine front panel: debounced buttons, program select, start/arm
// handshake, done buzzer, soap LED blink and BCD timer display.
module wm_control_panel
  import wm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ARM_TIMEOUT     = 8,
  parameter int BUZZ_CYCLES     = 16,
  parameter int BLINK_HALF      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_program,
  input  logic       btn_start,
  input  logic       lockDoor,
  input  logic       program_done,
  input  logic       soap_warning,
  input  logic [7:0] timer_display,
  output logic [2:0] program_selection,
  output logic       start,
  output logic [4:0] led_program,
  output logic       start_rejected,
  output logic       buzzer,
  output logic       soap_led,
  output logic [1:0] bcd_hundreds,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones
);
  localparam int AW = $clog2(ARM_TIMEOUT + 1);
  localparam int BZ = $clog2(BUZZ_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  logic [NUM_BTN-1:0] btn_raw, press;
  assign btn_raw = {btn_start, btn_program};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    wm_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .press (press[i])
    );
  end

  panel_t        state, state_nxt;
  prog_t         sel, sel_nxt;
  logic          start_nxt, rej_nxt;
  logic [AW-1:0] arm_cnt, arm_nxt;
  logic [BZ-1:0] buzz_cnt, buzz_nxt;

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    start_nxt = 1'b0;
    rej_nxt   = start_rejected;
    arm_nxt   = arm_cnt;
    buzz_nxt  = buzz_cnt;
    case (state)
      SELECT: begin
        // start wins over a simultaneous program press
        if (press[BTN_START]) begin
          state_nxt = ARMED;
          start_nxt = 1'b1;
          rej_nxt   = 1'b0;
          arm_nxt   = '0;
        end else if (press[BTN_PROG]) begin
          sel_nxt = (sel == WARM_WASH) ? COLD_WASH : prog_t'(sel + 3'd1);
        end
      end
      ARMED: begin
        if (lockDoor) begin
          state_nxt = RUNNING;
        end else if (arm_cnt == AW'(ARM_TIMEOUT - 1)) begin
          state_nxt = SELECT;
          rej_nxt   = 1'b1;
        end else begin
          arm_nxt = arm_cnt + 1'b1;
        end
      end
      RUNNING: begin
        if (program_done) begin
          state_nxt = DONE;
          buzz_nxt  = BZ'(BUZZ_CYCLES);
        end else if (!lockDoor) begin
          state_nxt = SELECT;
        end
      end
      DONE: begin
        if (buzz_cnt != '0) buzz_nxt = buzz_cnt - 1'b1;
        if (buzz_cnt <= BZ'(1)) state_nxt = SELECT;
      end
      default: state_nxt = SELECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= SELECT;
      sel            <= COLD_WASH;
      start          <= 1'b0;
      start_rejected <= 1'b0;
      arm_cnt        <= '0;
      buzz_cnt       <= '0;
    end else begin
      state          <= state_nxt;
      sel            <= sel_nxt;
      start          <= start_nxt;
      start_rejected <= rej_nxt;
      arm_cnt        <= arm_nxt;
      buzz_cnt       <= buzz_nxt;
    end
  end

  assign program_selection = sel;
  assign led_program       = 5'd1 << sel;
  assign buzzer            = (buzz_cnt != '0);

  // Soap LED: phase restarts on the warning's rising edge, LED on first.
  logic          soap_q, led_q;
  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      soap_q    <= 1'b0;
      led_q     <= 1'b0;
      blink_cnt <= '0;
    end else begin
      soap_q <= soap_warning;
      if (!soap_warning) begin
        led_q     <= 1'b0;
        blink_cnt <= '0;
      end else if (!soap_q) begin
        led_q     <= 1'b1;
        blink_cnt <= '0;
      end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
        led_q     <= ~led_q;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign soap_led = led_q & soap_warning;

  // Detect a new display value while idle; the converter captures it next cycle.
  logic       conv_go, conv_busy, conv_done_unused;
  logic [7:0] last_conv;

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_go   <= 1'b0;
      last_conv <= '0;
    end else begin
      conv_go <= !conv_go && !conv_busy && (timer_display != last_conv);
      if (conv_go) last_conv <= timer_display;
    end
  end

  wm_bin2bcd u_bcd (
    .clk      (clk),
    .rst      (rst),
    .start    (conv_go),
    .din      (timer_display),
    .busy     (conv_busy),
    .done     (conv_done_unused),
    .hundreds (bcd_hundreds),
    .tens     (bcd_tens),
    .ones     (bcd_ones)
  );

endmodule
